axi2mem_wr_channel: RTL and testbench
=====================================

// Module: axi2mem_wr_channel
// PURPOSE
//  AXI4 write-side slave channel of axi2mem. Accepts AW and W bursts from the AXI master.
//  Splits each 64-bit W beat into two 32-bit TCDM write requests (port 0 = low word, port 1 = +4).
//  Returns one B response per burst through a small ID FIFO.
//  Sits beside axi2mem_rd_channel and drives the same two-port TCDM command queue.
// PARAMETERS
//  AXI_ADDR_WIDTH  32  AXI address width
//  AXI_DATA_WIDTH  64  W data width; fixed at 64, 2x32-bit TCDM words
//  AXI_ID_WIDTH    3   AXI ID width
//  AXI_USER_WIDTH  6   AXI user width
//  B_FIFO_DEPTH    4   pending B responses held
// PORTS
//  clk_i                 in   1               clock
//  rst_ni                in   1               reset, asynchronous, active-low
//  axi_slave_aw_valid_i  in   1               AW valid
//  axi_slave_aw_addr_i   in   AXI_ADDR_WIDTH  burst start address
//  axi_slave_aw_len_i    in   8               beats-1
//  axi_slave_aw_size_i   in   3               ignored, 8-byte beats
//  axi_slave_aw_burst_i  in   2               ignored, all treated as INCR
//  axi_slave_aw_id_i     in   AXI_ID_WIDTH    burst ID
//  axi_slave_aw_user_i   in   AXI_USER_WIDTH  ignored
//  axi_slave_aw_ready_o  out  1               AW ready
//  axi_slave_w_valid_i   in   1               W valid
//  axi_slave_w_data_i    in   64              W data
//  axi_slave_w_strb_i    in   8               byte strobes
//  axi_slave_w_last_i    in   1               W last
//  axi_slave_w_ready_o   out  1               W ready
//  axi_slave_b_valid_o   out  1               B valid
//  axi_slave_b_resp_o    out  2               B response
//  axi_slave_b_id_o      out  AXI_ID_WIDTH    B ID
//  axi_slave_b_user_o    out  AXI_USER_WIDTH  tied 0
//  axi_slave_b_ready_i   in   1               B ready
//  trans_req_o           out  [1:0]           TCDM write request per port
//  trans_add_o           out  [1:0][31:0]     word address per port
//  trans_id_o            out  [1:0][5:0]      AW ID, zero-extended
//  trans_last_o          out  [1:0]           marks the last beat of the burst
//  trans_wdata_o         out  [1:0][31:0]     port0 = w_data[31:0], port1 = w_data[63:32]
//  trans_be_o            out  [1:0][3:0]      port0 = strb[3:0], port1 = strb[7:4]
//  trans_gnt_i           in   [1:0]           TCDM queue can accept, per port
// BEHAVIOUR
//  Reset: aw_ready=0, w_ready=0, b_valid=0, trans_req=0. FSM=IDLE, beat counter=0, B FIFO empty.
//  FSM IDLE:
//   - aw_ready=1 iff B FIFO occupancy < B_FIFO_DEPTH; this reserves the slot for the burst.
//   - On AW handshake: latch {addr[31:3],3'b000}, len, id; counter<=0; ->RUN.
//   - W is never accepted in IDLE. First beat is earliest 1 cycle after the AW handshake.
//  FSM RUN:
//   - aw_ready=0.
//   - When w_valid && trans_gnt_i==2'b11: w_ready=1, trans_req=2'b11.
//   - Addresses: add[0]=base+(count<<3), add[1]=add[0]+4. 32-bit modular add, wraps silently.
//   - Count width is 8 bits.
//   - If count==len: trans_last=2'b11, push {id,resp} into the B FIFO, ->IDLE. Otherwise count++.
//   - Partial grant (only one gnt bit set): no request, no w_ready; the beat is held.
//  Requests are issued even when be==4'h0, keeping order and last marking intact.
//  B channel: b_valid = FIFO not empty; pop on b_valid && b_ready.
//   - Push and pop in the same cycle: both happen, occupancy unchanged.
//   - Latency: last beat accepted in cycle N -> b_valid at cycle N+1 at the earliest.
//  Reset mid-burst: burst aborted, pending B responses discarded, no further TCDM requests.
// CONFIGURATION
//  AXI2MEM_WR_SLVERR_EN defined:
//   - w_last must equal (count==len) on every accepted beat.
//   - Any mismatch sets a sticky error flag for the burst; its B resp = 2'b10 (SLVERR).
//   - The burst still ends on count==len, not on w_last.
//  AXI2MEM_WR_SLVERR_EN undefined: w_last ignored; resp always 2'b00 (OKAY).
// STRUCTURE
//  Shared package axi2mem_pkg holds:
//   - resp codes AXI_RESP_OKAY / AXI_RESP_SLVERR
//   - wr FSM state enum {WR_IDLE, WR_RUN}
//   - TCDM_PORTS=2, TCDM_ID_WIDTH=6
//  Sub-module: axi2mem_buffer instance as the B FIFO, DATA_WIDTH=AXI_ID_WIDTH+2, depth B_FIFO_DEPTH.
// TESTING
//  1 Single beat:
//    AW addr=0x1004 len=0 id=5; W data=0xAABBCCDD_11223344 strb=0xFF.
//    -> req 2'b11, add={0x1000,0x1004}, wdata={0x11223344,0xAABBCCDD}, last=2'b11.
//    -> B id=5 resp=0.
//  2 INCR burst, len=3, base 0x2000, gnt always 1.
//    -> 4 beats at 0x2000/08/10/18; last only on beat 4; exactly one B.
//  3 Backpressure:
//    gnt=2'b01 for 3 cycles during beat 2 -> no req, w_ready=0; beat resumes when gnt=2'b11.
//    Strobe check: strb=0x0F -> be={4'hF,4'h0}.
//  4 B FIFO full:
//    b_ready=0, issue 4 single-beat bursts -> 5th AW sees aw_ready=0.
//    Raise b_ready 1 cycle -> IDs pop in order, aw_ready=1 next cycle.
//  5 Wrap: AW addr=0xFFFFFFF8 len=1 -> second beat add[0]=0x00000000.
//  6 With AXI2MEM_WR_SLVERR_EN: len=2, w_last on beat 2 -> 3 beats issued, B resp=2'b10.
//    Without the macro -> resp=2'b00.
//    Additional check: assert rst_ni mid-burst -> all outputs 0 and b_valid=0.

Source files
------------

// File: rtl/axi2mem_pkg.sv
// Shared definitions for the axi2mem read/write channels: AXI response codes,
// write-channel FSM states and the TCDM command-queue geometry.
package axi2mem_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int unsigned TCDM_PORTS    = 2;
  localparam int unsigned TCDM_ID_WIDTH = 6;

  typedef enum logic {
    WR_IDLE,
    WR_RUN
  } wr_state_e;

endpackage

// File: rtl/axi2mem_buffer.sv
// Small synchronous FIFO. Used by the write channel to hold pending B responses.
// Push while full is ignored unless a pop happens in the same cycle.
module axi2mem_buffer #(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array, written on push.
  // NOTE: the storage has no reset; emptiness is tracked by the counter, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/axi2mem_wr_channel.sv
// AXI4 write-side slave channel of axi2mem. Each 64-bit W beat becomes two
// 32-bit TCDM write requests issued together; one B response per burst is
// queued in a small FIFO. Optional build macro AXI2MEM_WR_SLVERR_EN enables
// w_last checking with SLVERR reporting.
module axi2mem_wr_channel
  import axi2mem_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 3,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned B_FIFO_DEPTH   = 4
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      axi_slave_aw_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]                 axi_slave_aw_addr_i,
  input  logic [7:0]                                axi_slave_aw_len_i,
  input  logic [2:0]                                axi_slave_aw_size_i,
  input  logic [1:0]                                axi_slave_aw_burst_i,
  input  logic [AXI_ID_WIDTH-1:0]                   axi_slave_aw_id_i,
  input  logic [AXI_USER_WIDTH-1:0]                 axi_slave_aw_user_i,
  output logic                                      axi_slave_aw_ready_o,
  input  logic                                      axi_slave_w_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0]                 axi_slave_w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]               axi_slave_w_strb_i,
  input  logic                                      axi_slave_w_last_i,
  output logic                                      axi_slave_w_ready_o,
  output logic                                      axi_slave_b_valid_o,
  output logic [1:0]                                axi_slave_b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]                   axi_slave_b_id_o,
  output logic [AXI_USER_WIDTH-1:0]                 axi_slave_b_user_o,
  input  logic                                      axi_slave_b_ready_i,
  output logic [TCDM_PORTS-1:0]                     trans_req_o,
  output logic [TCDM_PORTS-1:0][31:0]               trans_add_o,
  output logic [TCDM_PORTS-1:0][TCDM_ID_WIDTH-1:0]  trans_id_o,
  output logic [TCDM_PORTS-1:0]                     trans_last_o,
  output logic [TCDM_PORTS-1:0][31:0]               trans_wdata_o,
  output logic [TCDM_PORTS-1:0][3:0]                trans_be_o,
  input  logic [TCDM_PORTS-1:0]                     trans_gnt_i
);

  localparam int unsigned B_WIDTH = AXI_ID_WIDTH + 2;

  wr_state_e               state_q, state_d;
  logic [31:0]             base_q, base_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              count_q, count_d;
  logic [AXI_ID_WIDTH-1:0] id_q, id_d;
  logic                    live_q;
  logic                    aw_accept, beat_fire, is_last, b_push, b_pop, b_full, b_empty;
  logic [1:0]              push_resp;
  logic [B_WIDTH-1:0]      b_rdata;
  logic [31:0]             beat_addr;
  logic                    unused_inputs;
`ifdef AXI2MEM_WR_SLVERR_EN
  logic                    err_q, err_d, beat_err;
`endif

  assign is_last   = (count_q == len_q);
  assign beat_addr = base_q + 32'({count_q, 3'b000});

  // FSM state and burst context registers; live_q keeps aw_ready low while in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WR_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      id_q    <= '0;
      live_q  <= 1'b0;
`ifdef AXI2MEM_WR_SLVERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      count_q <= count_d;
      id_q    <= id_d;
      live_q  <= 1'b1;
`ifdef AXI2MEM_WR_SLVERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state and handshake logic: take AW in IDLE, stream W beats in RUN.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    state_d              = state_q;
    base_d               = base_q;
    len_d                = len_q;
    count_d              = count_q;
    id_d                 = id_q;
    axi_slave_aw_ready_o = 1'b0;
    axi_slave_w_ready_o  = 1'b0;
    aw_accept            = 1'b0;
    beat_fire            = 1'b0;
    b_push               = 1'b0;
    push_resp            = AXI_RESP_OKAY;
`ifdef AXI2MEM_WR_SLVERR_EN
    err_d                = err_q;
    beat_err             = 1'b0;
`endif
    case (state_q)
      WR_IDLE: begin
        // A free FIFO slot here is the reservation for this burst's B response.
        axi_slave_aw_ready_o = live_q && !b_full;
        aw_accept            = axi_slave_aw_valid_i && live_q && !b_full;
        if (aw_accept) begin
          base_d  = {axi_slave_aw_addr_i[31:3], 3'b000};
          len_d   = axi_slave_aw_len_i;
          id_d    = axi_slave_aw_id_i;
          count_d = '0;
`ifdef AXI2MEM_WR_SLVERR_EN
          err_d   = 1'b0;
`endif
          state_d = WR_RUN;
        end
      end
      WR_RUN: begin
        // Both TCDM ports must grant; a partial grant holds the beat untouched.
        beat_fire           = axi_slave_w_valid_i && (trans_gnt_i == 2'b11);
        axi_slave_w_ready_o = beat_fire;
`ifdef AXI2MEM_WR_SLVERR_EN
        beat_err  = beat_fire && (axi_slave_w_last_i != is_last);
        err_d     = err_q | beat_err;
        push_resp = (err_q || beat_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
`endif
        if (beat_fire) begin
          if (is_last) begin
            b_push  = 1'b1;
            state_d = WR_IDLE;
          end else begin
            count_d = count_q + 8'd1;
          end
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // TCDM request fan-out; all fields are zero when no beat is issued.
  always_comb begin
    trans_req_o   = '0;
    trans_add_o   = '0;
    trans_id_o    = '0;
    trans_last_o  = '0;
    trans_wdata_o = '0;
    trans_be_o    = '0;
    if (beat_fire) begin
      trans_req_o      = {TCDM_PORTS{1'b1}};
      trans_add_o[0]   = beat_addr;
      trans_add_o[1]   = beat_addr + 32'd4;
      trans_id_o[0]    = TCDM_ID_WIDTH'(id_q);
      trans_id_o[1]    = TCDM_ID_WIDTH'(id_q);
      trans_last_o     = {TCDM_PORTS{is_last}};
      trans_wdata_o[0] = axi_slave_w_data_i[31:0];
      trans_wdata_o[1] = axi_slave_w_data_i[63:32];
      trans_be_o[0]    = axi_slave_w_strb_i[3:0];
      trans_be_o[1]    = axi_slave_w_strb_i[7:4];
    end
  end

  assign b_pop = axi_slave_b_valid_o && axi_slave_b_ready_i;

  axi2mem_buffer #(
    .DATA_WIDTH (B_WIDTH),
    .DEPTH      (B_FIFO_DEPTH)
  ) i_b_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (b_push),
    .data_i  ({id_q, push_resp}),
    .pop_i   (b_pop),
    .data_o  (b_rdata),
    .empty_o (b_empty),
    .full_o  (b_full)
  );

  assign axi_slave_b_valid_o = !b_empty;
  assign axi_slave_b_id_o    = b_rdata[B_WIDTH-1:2];
  assign axi_slave_b_resp_o  = b_rdata[1:0];
  assign axi_slave_b_user_o  = '0;

  // Beats are always 8 bytes and always INCR, so size, burst, user and the
  // low address bits carry no information here.
`ifdef AXI2MEM_WR_SLVERR_EN
  assign unused_inputs = ^{axi_slave_aw_size_i, axi_slave_aw_burst_i,
                           axi_slave_aw_user_i, axi_slave_aw_addr_i[2:0]};
`else
  assign unused_inputs = ^{axi_slave_aw_size_i, axi_slave_aw_burst_i,
                           axi_slave_aw_user_i, axi_slave_aw_addr_i[2:0],
                           axi_slave_w_last_i};
`endif

endmodule

// File: tb/tb_axi2mem_wr_channel.sv
// Self-checking bench for axi2mem_wr_channel: a table of single-beat vectors,
// hand-written multi-cycle sequences, and randomized bursts checked against a
// queue-based reference model.
module tb_axi2mem_wr_channel;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             aw_valid;
  logic [31:0]      aw_addr;
  logic [7:0]       aw_len;
  logic [2:0]       aw_size;
  logic [1:0]       aw_burst;
  logic [2:0]       aw_id;
  logic [5:0]       aw_user;
  logic             aw_ready;
  logic             w_valid;
  logic [63:0]      w_data;
  logic [7:0]       w_strb;
  logic             w_last;
  logic             w_ready;
  logic             b_valid;
  logic [1:0]       b_resp;
  logic [2:0]       b_id;
  logic [5:0]       b_user;
  logic             b_ready;
  logic [1:0]       trans_req;
  logic [1:0][31:0] trans_add;
  logic [1:0][5:0]  trans_id;
  logic [1:0]       trans_last;
  logic [1:0][31:0] trans_wdata;
  logic [1:0][3:0]  trans_be;
  logic [1:0]       trans_gnt;

  int checks   = 0;
  int failures = 0;
  bit model_en = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  id;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [31:0] add0, add1, wd0, wd1;
    logic [3:0]  be0, be1;
  } vec_t;

  typedef struct {
    logic [31:0] add0;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [2:0]  id;
  } exp_req_t;

  typedef struct {
    logic [2:0] id;
    logic [1:0] resp;
  } exp_b_t;

  exp_req_t exp_req_q [$];
  exp_b_t   exp_b_q [$];
  vec_t     vecs [4];

  axi2mem_wr_channel dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .axi_slave_aw_valid_i (aw_valid),
    .axi_slave_aw_addr_i  (aw_addr),
    .axi_slave_aw_len_i   (aw_len),
    .axi_slave_aw_size_i  (aw_size),
    .axi_slave_aw_burst_i (aw_burst),
    .axi_slave_aw_id_i    (aw_id),
    .axi_slave_aw_user_i  (aw_user),
    .axi_slave_aw_ready_o (aw_ready),
    .axi_slave_w_valid_i  (w_valid),
    .axi_slave_w_data_i   (w_data),
    .axi_slave_w_strb_i   (w_strb),
    .axi_slave_w_last_i   (w_last),
    .axi_slave_w_ready_o  (w_ready),
    .axi_slave_b_valid_o  (b_valid),
    .axi_slave_b_resp_o   (b_resp),
    .axi_slave_b_id_o     (b_id),
    .axi_slave_b_user_o   (b_user),
    .axi_slave_b_ready_i  (b_ready),
    .trans_req_o          (trans_req),
    .trans_add_o          (trans_add),
    .trans_id_o           (trans_id),
    .trans_last_o         (trans_last),
    .trans_wdata_o        (trans_wdata),
    .trans_be_o           (trans_be),
    .trans_gnt_i          (trans_gnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: every issued TCDM request must match the next expected beat.
  always @(negedge clk_i) begin
    exp_req_t e;
    if (rst_ni && model_en && trans_req != 2'b00) begin
      if (exp_req_q.size() == 0) begin
        check("unexpected_req", trans_req, 2'b00);
      end else begin
        e = exp_req_q.pop_front();
        check("m_req",   trans_req, 2'b11);
        check("m_add0",  trans_add[0], e.add0);
        check("m_add1",  trans_add[1], e.add0 + 32'd4);
        check("m_wd0",   trans_wdata[0], e.data[31:0]);
        check("m_wd1",   trans_wdata[1], e.data[63:32]);
        check("m_be0",   trans_be[0], e.strb[3:0]);
        check("m_be1",   trans_be[1], e.strb[7:4]);
        check("m_last",  trans_last, {2{e.last}});
        check("m_id0",   trans_id[0], {3'b000, e.id});
        check("m_id1",   trans_id[1], {3'b000, e.id});
      end
    end
  end

  // Reference model: every B handshake must match the next expected response, in order.
  always @(negedge clk_i) begin
    exp_b_t e;
    if (rst_ni && model_en && b_valid && b_ready) begin
      if (exp_b_q.size() == 0) begin
        check("unexpected_b", b_valid, 1'b0);
      end else begin
        e = exp_b_q.pop_front();
        check("m_b_id",   b_id, e.id);
        check("m_b_resp", b_resp, e.resp);
        check("m_b_user", b_user, 6'd0);
      end
    end
  end

  task automatic aw_hs(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] id);
    int n;
    bit hs;
    aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_id = id;
    aw_size = 3'd3; aw_burst = 2'b01; aw_user = 6'($urandom);
    n = 0; hs = 1'b0;
    while (!hs && n < 200) begin
      @(negedge clk_i);
      hs = aw_ready;
      @(posedge clk_i); #1;
      n++;
    end
    aw_valid = 1'b0;
    check("aw_handshake", hs, 1'b1);
  endtask

  // gnt_mode: 0 = always granted, 1 = random grants, 2 = beat 1 sees gnt=01 for 3 cycles.
  task automatic send_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] id,
                            input int last_at, input int gnt_mode,
                            input logic [7:0] strb_fix, input bit strb_rand);
    logic [63:0] data [$];
    logic [7:0]  strb [$];
    logic [31:0] base;
    bit          err;
    exp_b_t      eb;
    int          n, stall;
    bit          hs, exp_rdy;
    base = {addr[31:3], 3'b000};
    err  = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      exp_req_t e;
      data.push_back({$urandom, $urandom});
      strb.push_back(strb_rand ? 8'($urandom) : strb_fix);
      e.add0 = base + 32'(i * 8);
      e.data = data[i];
      e.strb = strb[i];
      e.last = (i == int'(len));
      e.id   = id;
      exp_req_q.push_back(e);
      if ((i == last_at) != (i == int'(len))) err = 1'b1;
    end
    eb.id = id;
`ifdef AXI2MEM_WR_SLVERR_EN
    eb.resp = err ? 2'b10 : 2'b00;
`else
    eb.resp = 2'b00;
`endif
    exp_b_q.push_back(eb);
    aw_hs(addr, len, id);
    for (int i = 0; i <= int'(len); i++) begin
      w_valid = 1'b1; w_data = data[i]; w_strb = strb[i]; w_last = (i == last_at);
      n = 0; stall = 0; hs = 1'b0;
      while (!hs && n < 200) begin
        case (gnt_mode)
          1:       trans_gnt = 2'($urandom);
          2:       trans_gnt = (i == 1 && stall < 3) ? 2'b01 : 2'b11;
          default: trans_gnt = 2'b11;
        endcase
        @(negedge clk_i);
        exp_rdy = (trans_gnt == 2'b11);
        check("w_ready", w_ready, exp_rdy);
        check("req_vs_gnt", trans_req, {2{exp_rdy}});
        hs = w_ready;
        @(posedge clk_i); #1;
        if (trans_gnt != 2'b11) stall++;
        n++;
      end
      check("w_handshake", hs, 1'b1);
      if (gnt_mode == 2 && i == 1) check("stall_cycles", stall, 3);
    end
    w_valid = 1'b0; w_last = 1'b0; trans_gnt = 2'b11;
  endtask

  task automatic drain_b();
    int n;
    b_ready = 1'b1;
    n = 0;
    while (exp_b_q.size() != 0 && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("b_drained", exp_b_q.size(), 0);
    check("req_drained", exp_req_q.size(), 0);
  endtask

  initial begin
    int       last_at;
    logic [7:0] len;

    vecs[0] = '{32'h0000_1004, 3'd5, 64'hAABBCCDD_11223344, 8'hFF,
                32'h0000_1000, 32'h0000_1004, 32'h1122_3344, 32'hAABB_CCDD, 4'hF, 4'hF};
    vecs[1] = '{32'h0000_2FFF, 3'd2, 64'h01234567_89ABCDEF, 8'h0F,
                32'h0000_2FF8, 32'h0000_2FFC, 32'h89AB_CDEF, 32'h0123_4567, 4'hF, 4'h0};
    vecs[2] = '{32'hFFFF_FFFC, 3'd7, 64'hDEADBEEF_CAFEF00D, 8'hA5,
                32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'hDEAD_BEEF, 4'h5, 4'hA};
    vecs[3] = '{32'h0000_0008, 3'd0, 64'h0, 8'h00,
                32'h0000_0008, 32'h0000_000C, 32'h0, 32'h0, 4'h0, 4'h0};

    rst_ni = 1'b0; aw_valid = 1'b0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
    aw_id = '0; aw_user = '0; w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0;
    b_ready = 1'b1; trans_gnt = 2'b11;

    // Reset state.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_aw_ready", aw_ready, 1'b0);
    check("rst_w_ready", w_ready, 1'b0);
    check("rst_b_valid", b_valid, 1'b0);
    check("rst_trans_req", trans_req, 2'b00);
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i); #1;

    // Table-driven single-beat bursts, including B latency of one cycle.
    for (int k = 0; k < 4; k++) begin
      aw_hs(vecs[k].addr, 8'd0, vecs[k].id);
      w_valid = 1'b1; w_data = vecs[k].data; w_strb = vecs[k].strb; w_last = 1'b1;
      @(negedge clk_i);
      check("t_b_valid_before", b_valid, 1'b0);
      check("t_req", trans_req, 2'b11);
      check("t_add0", trans_add[0], vecs[k].add0);
      check("t_add1", trans_add[1], vecs[k].add1);
      check("t_wd0", trans_wdata[0], vecs[k].wd0);
      check("t_wd1", trans_wdata[1], vecs[k].wd1);
      check("t_be0", trans_be[0], vecs[k].be0);
      check("t_be1", trans_be[1], vecs[k].be1);
      check("t_last", trans_last, 2'b11);
      check("t_id0", trans_id[0], {3'b000, vecs[k].id});
      @(posedge clk_i); #1;
      w_valid = 1'b0; w_last = 1'b0;
      @(negedge clk_i);
      check("t_b_valid_after", b_valid, 1'b1);
      check("t_b_id", b_id, vecs[k].id);
      check("t_b_resp", b_resp, 2'b00);
      check("t_req_idle", trans_req, 2'b00);
      @(posedge clk_i); #1;
    end

    model_en = 1'b1;
    // INCR burst of 4 beats.
    send_burst(32'h0000_2000, 8'd3, 3'd2, 3, 0, 8'hFF, 1'b0);
    drain_b();
    // Partial grant stall on beat 2, with a 0x0F strobe.
    send_burst(32'h0000_3000, 8'd2, 3'd3, 2, 2, 8'h0F, 1'b0);
    drain_b();
    // Address wrap across 2^32.
    send_burst(32'hFFFF_FFF8, 8'd1, 3'd4, 1, 0, 8'hFF, 1'b1);
    drain_b();
    // Early w_last: SLVERR only when the checking build option is on.
    send_burst(32'h0000_6000, 8'd2, 3'd5, 1, 0, 8'hFF, 1'b0);
    drain_b();

    // B FIFO full: four pending responses block the next AW.
    b_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_burst(32'h0000_4000 + 32'(i * 64), 8'd0, 3'(i + 1), 0, 0, 8'hFF, 1'b0);
    @(negedge clk_i);
    check("full_aw_ready", aw_ready, 1'b0);
    check("full_b_valid", b_valid, 1'b1);
    @(negedge clk_i);
    check("full_aw_ready_hold", aw_ready, 1'b0);
    @(posedge clk_i); #1;
    b_ready = 1'b1;
    @(posedge clk_i); #1;
    b_ready = 1'b0;
    @(negedge clk_i);
    check("aw_ready_after_pop", aw_ready, 1'b1);
    check("b_left_after_pop", exp_b_q.size(), 3);
    @(posedge clk_i); #1;
    drain_b();

    // Randomized bursts against the reference model.
    for (int t = 0; t < 25; t++) begin
      len = 8'($urandom_range(0, 7));
      last_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(len))) : int'(len);
      send_burst($urandom, len, 3'($urandom), last_at, 1, 8'h00, 1'b1);
      b_ready = 1'($urandom_range(0, 1));
      if (exp_b_q.size() >= 3) drain_b();
    end
    drain_b();

    // Reset in the middle of a burst with a response still pending.
    b_ready = 1'b0;
    send_burst(32'h0000_7000, 8'd0, 3'd6, 0, 0, 8'hFF, 1'b0);
    model_en = 1'b0;
    aw_hs(32'h0000_5000, 8'd3, 3'd7);
    w_valid = 1'b1; w_data = 64'h5555_AAAA_1234_5678; w_strb = 8'hFF; w_last = 1'b0;
    @(posedge clk_i); #1;
    check("mid_req_before_rst", trans_req, 2'b11);
    check("mid_b_pending", b_valid, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_req", trans_req, 2'b00);
    check("mid_rst_w_ready", w_ready, 1'b0);
    check("mid_rst_aw_ready", aw_ready, 1'b0);
    check("mid_rst_b_valid", b_valid, 1'b0);
    check("mid_rst_add0", trans_add[0], 32'h0);
    check("mid_rst_last", trans_last, 2'b00);
    exp_req_q.delete();
    exp_b_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("post_rst_b_valid", b_valid, 1'b0);
    check("post_rst_req", trans_req, 2'b00);
    check("post_rst_w_ready", w_ready, 1'b0);
    check("post_rst_aw_ready", aw_ready, 1'b1);
    @(posedge clk_i); #1;
    w_valid = 1'b0;
    b_ready = 1'b1;
    model_en = 1'b1;
    send_burst(32'h0000_8000, 8'd1, 3'd1, 1, 0, 8'hFF, 1'b1);
    drain_b();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
